// File: rtl/seg_mux_decoder_if.sv
// seg_mux_decoder_if: multiplexed 7-segment bus plus recovered-digit outputs of the decoder.
interface seg_mux_decoder_if #(
  parameter int N_DIG = 4
);
  localparam int PW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  logic [6:0]         segmentos;
  logic [N_DIG-1:0]   anodos;
  logic [4*N_DIG-1:0] digitos;
  logic               valido;
  logic [PW-1:0]      posicao;
  logic [3:0]         digito;
  logic               erro;
  logic               quadro;
  modport master (
    output segmentos, anodos,
    input  digitos, valido, posicao, digito, erro, quadro
  );
  modport slave (
    input  segmentos, anodos,
    output digitos, valido, posicao, digito, erro, quadro
  );
endinterface

// File: rtl/seg_mux_decoder.sv
// seg_mux_decoder: recovers per-position BCD digits from an active-low multiplexed 7-segment bus.
module seg_mux_decoder #(
  parameter int N_DIG         = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic clk,
  input logic rst_n,
  seg_mux_decoder_if.slave dsp
);
  localparam int PW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         seg_q, seg_p_q;
  logic [N_DIG-1:0]   an_q, an_p_q;
  logic [4*N_DIG-1:0] dig_q;
  logic [N_DIG-1:0]   mask_q, mask_set;
  logic               valido_q, erro_q, quadro_q;
  logic [PW-1:0]      posicao_q, pos;
  logic [3:0]         digito_q, dec_v;
  logic               dec_ok, an_ok, chg, acc, acc_ok, frame;
  always_comb begin
    dec_v  = 4'h0;
    dec_ok = 1'b1;
    case (seg_q)
      7'b1000000: dec_v = 4'd0;
      7'b1111001: dec_v = 4'd1;
      7'b0100100: dec_v = 4'd2;
      7'b0110000: dec_v = 4'd3;
      7'b0011001: dec_v = 4'd4;
      7'b0010010: dec_v = 4'd5;
      7'b0000010: dec_v = 4'd6;
      7'b1111000: dec_v = 4'd7;
      7'b0000000: dec_v = 4'd8;
      7'b0010000: dec_v = 4'd9;
      7'b1111111: dec_v = 4'hF;
      default:    dec_ok = 1'b0;
    endcase
  end
  always_comb begin
    pos = '0;
    for (int i = 0; i < N_DIG; i++)
      if (!an_q[i]) pos = PW'(i);
  end
  assign an_ok = ($countones(~an_q) == 1);
  assign chg   = {seg_q, an_q} != {seg_p_q, an_p_q};
  // Acceptance fires only when the count first lands on STABLE_CYCLES, so HOLD never re-pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!an_ok) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE || chg) begin
      state_d = TRACK;
      cnt_d   = CNT_W'(1);
    end else if (state_q == TRACK) begin
      cnt_d = (cnt_q >= CNT_W'(STABLE_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    acc = an_ok && (state_q != HOLD || chg) && (cnt_d == CNT_W'(STABLE_CYCLES));
    if (acc) state_d = HOLD;
  end
  assign acc_ok   = acc && dec_ok;
  assign mask_set = mask_q | (N_DIG'(1) << pos);
  assign frame    = acc_ok && (&mask_set);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= '1;
      seg_p_q   <= '1;
      an_q      <= '1;
      an_p_q    <= '1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      dig_q     <= {N_DIG{4'hF}};
      mask_q    <= '0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
      quadro_q  <= 1'b0;
      posicao_q <= '0;
      digito_q  <= 4'h0;
    end else begin
      seg_q    <= dsp.segmentos;
      an_q     <= dsp.anodos;
      seg_p_q  <= seg_q;
      an_p_q   <= an_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valido_q <= acc_ok;
      erro_q   <= acc && !dec_ok;
      quadro_q <= frame;
      if (acc_ok) begin
        posicao_q              <= pos;
        digito_q               <= dec_v;
        dig_q[4*int'(pos) +: 4] <= dec_v;
        mask_q                 <= frame ? '0 : mask_set;
      end
    end
  end
  assign dsp.digitos = dig_q;
  assign dsp.valido  = valido_q;
  assign dsp.erro    = erro_q;
  assign dsp.quadro  = quadro_q;
  assign dsp.posicao = posicao_q;
  assign dsp.digito  = digito_q;
endmodule

// File: tb/tb_seg_mux_decoder.sv
// tb_seg_mux_decoder: randomized and directed checks of seg_mux_decoder against a run-length model.
module tb_seg_mux_decoder;
  localparam int N = 4;
  localparam int S = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  seg_mux_decoder_if #(.N_DIG(N)) dif ();
  seg_mux_decoder #(.N_DIG(N), .STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dsp  (dif)
  );
  always #5 clk = ~clk;
  logic [6:0]  ps;
  logic [3:0]  pa;
  int          run;
  logic [15:0] m_digits;
  logic [3:0]  m_mask;
  logic        m_v, m_e, m_q;
  logic [1:0]  m_pos;
  logic [3:0]  m_dig;
  logic [6:0]  pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  wire  [24:0] obs = {dif.valido, dif.erro, dif.quadro, dif.posicao, dif.digito, dif.digitos};
  function automatic logic [24:0] expv();
    return {m_v, m_e, m_q, m_pos, m_dig, m_digits};
  endfunction
  function automatic void model_reset();
    ps = 7'h7F; pa = 4'hF; run = 0;
    m_digits = 16'hFFFF; m_mask = 4'h0;
    m_v = 0; m_e = 0; m_q = 0; m_pos = 0; m_dig = 0;
  endfunction
  // Model: a sample run of exactly S identical samples on one low anode is accepted one edge later.
  task automatic step(input logic [6:0] s, input logic [3:0] a);
    logic ok;
    logic [3:0] v;
    int p;
    dif.segmentos = s;
    dif.anodos = a;
    @(posedge clk);
    #1;
    m_v = 0; m_e = 0; m_q = 0;
    if (run == S && $countones(~pa) == 1) begin
      ok = (ps == 7'h7F);
      v = 4'hF;
      for (int k = 0; k < 10; k++) if (pats[k] == ps) begin ok = 1; v = 4'(k); end
      p = 0;
      for (int k = 0; k < N; k++) if (!pa[k]) p = k;
      if (ok) begin
        m_v = 1; m_pos = 2'(p); m_dig = v;
        m_digits[4*p +: 4] = v;
        m_mask[p] = 1'b1;
        if (&m_mask) begin m_q = 1; m_mask = 4'h0; end
      end else m_e = 1;
    end
    run = ({s, a} == {ps, pa}) ? (run < 1000 ? run + 1 : run) : 1;
    ps = s;
    pa = a;
  endtask
  task automatic do_reset();
    rst_n = 0;
    dif.segmentos = 7'h7F;
    dif.anodos = 4'hF;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    do_reset();
    rst_n = 0;
    #2;
    checks++;
    if (obs !== 25'h000FFFF) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, 25'h000FFFF); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      step(7'($urandom), 4'hF);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL reset_idle[%0d] got=%h exp=%h", i, obs, expv()); end
    end
  endtask
  task automatic test_single_digit();
    int n = 0, at = -1;
    for (int i = 0; i < 10; i++) begin
      step(7'b0110000, 4'b1110);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL single[%0d] got=%h exp=%h", i, obs, expv()); end
      if (dif.valido) begin n++; at = i; end
    end
    checks++;
    if (n != 1 || at != 4) begin failures++; $display("FAIL single_latency got=%0d pulses at %0d exp=1 at 4", n, at); end
    checks++;
    if (dif.digitos[3:0] !== 4'd3) begin failures++; $display("FAIL single_reg got=%h exp=3", dif.digitos[3:0]); end
  endtask
  task automatic test_glitch();
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      step((i % 4) < 2 ? 7'b0010010 : 7'b0000010, 4'b1101);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL glitch[%0d] got=%h exp=%h", i, obs, expv()); end
      if (dif.valido) n++;
    end
    checks++;
    if (n != 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", n); end
    for (int i = 0; i < 6; i++) begin
      step(7'b0000010, 4'b1101);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL glitch_hold[%0d] got=%h exp=%h", i, obs, expv()); end
      if (dif.valido) n++;
    end
    checks++;
    if (n != 1 || dif.digitos[7:4] !== 4'd6) begin failures++; $display("FAIL glitch_accept got=%0d/%h exp=1/6", n, dif.digitos[7:4]); end
  endtask
  task automatic test_full_frame();
    logic [6:0] seq [4] = '{7'b1111001, 7'b0100100, 7'b1111000, 7'b0010000};
    int nv = 0, nq = 0, qat = -1;
    do_reset();
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 6; i++) begin
        step(seq[p], ~(4'(1) << p));
        checks++;
        if (obs !== expv()) begin failures++; $display("FAIL frame[%0d.%0d] got=%h exp=%h", p, i, obs, expv()); end
        if (dif.valido) nv++;
        if (dif.quadro) begin nq++; qat = nv; end
      end
    checks++;
    if (nv != 4 || nq != 1 || qat != 4) begin failures++; $display("FAIL frame_pulses got=v%0d q%0d@%0d exp=v4 q1@4", nv, nq, qat); end
    checks++;
    if (dif.digitos !== 16'h9721) begin failures++; $display("FAIL frame_digits got=%h exp=9721", dif.digitos); end
    nq = 0;
    for (int i = 0; i < 6; i++) begin
      step(7'b1111001, 4'b1110);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL frame_after[%0d] got=%h exp=%h", i, obs, expv()); end
      if (dif.quadro) nq++;
    end
    checks++;
    if (nq != 0) begin failures++; $display("FAIL mask_cleared got=%0d quadro exp=0", nq); end
  endtask
  task automatic test_errors();
    int ne = 0, nv = 0;
    for (int i = 0; i < 6; i++) begin
      step(7'b0101010, 4'b1011);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL err[%0d] got=%h exp=%h", i, obs, expv()); end
      if (dif.erro) ne++;
      if (dif.valido) nv++;
    end
    checks++;
    if (ne != 1 || nv != 0 || dif.digitos !== 16'h9721) begin failures++; $display("FAIL err_pulse got=e%0d v%0d %h exp=e1 v0 9721", ne, nv, dif.digitos); end
    for (int i = 0; i < 6; i++) begin
      step(7'b0000000, 4'b1001);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL bad_anode[%0d] got=%h exp=%h", i, obs, expv()); end
      if (dif.valido || dif.erro) nv++;
    end
    checks++;
    if (nv != 0) begin failures++; $display("FAIL bad_anode_pulses got=%0d exp=0", nv); end
    for (int i = 0; i < 6; i++) begin
      step(7'b1111111, 4'b0111);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL blank[%0d] got=%h exp=%h", i, obs, expv()); end
    end
    checks++;
    if (dif.digitos !== 16'hF721) begin failures++; $display("FAIL blank_digits got=%h exp=F721", dif.digitos); end
  endtask
  task automatic test_random();
    logic [3:0] ans [7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1001, 4'b0000};
    logic [6:0] s;
    logic [3:0] a;
    int r;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 12);
      s = (r < 10) ? pats[r] : (r == 10) ? 7'h7F : 7'($urandom);
      a = ans[($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 6)];
      for (int i = $urandom_range(1, 7); i > 0; i--) begin
        step(s, a);
        checks++;
        if (obs !== expv()) begin failures++; $display("FAIL random[%0d] got=%h exp=%h", t, obs, expv()); end
      end
    end
  endtask
  task automatic test_reset_mid_dwell();
    int nv = 0;
    for (int i = 0; i < 3; i++) begin
      step(7'b0010010, 4'b1110);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL dwell[%0d] got=%h exp=%h", i, obs, expv()); end
    end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (obs !== 25'h000FFFF) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, 25'h000FFFF); end
    repeat (4) begin
      @(posedge clk);
      #1;
      if (dif.valido) nv++;
    end
    checks++;
    if (nv != 0 || obs !== 25'h000FFFF) begin failures++; $display("FAIL reset_hold got=%0d/%h exp=0/%h", nv, obs, 25'h000FFFF); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step(7'b0010010, 4'b1110);
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL post_reset[%0d] got=%h exp=%h", i, obs, expv()); end
    end
  endtask
  initial begin
    dif.segmentos = 7'h7F;
    dif.anodos = 4'hF;
    model_reset();
    test_reset();
    test_single_digit();
    test_glitch();
    test_full_frame();
    test_errors();
    test_random();
    test_reset_mid_dwell();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_mux_decoder.md
Name: seg_mux_decoder

Overview:
- Monitors a time-multiplexed, active-low 7-segment display bus (segment lines plus anode selects) and recovers the BCD digit shown on each position.
- Inverse of the team's digit-to-segment encoder. Used as an on-chip self-check of the stopwatch display path and as a bench/loopback observer.
- Accepts a pattern only after it is stable for a programmable dwell.
- Keeps a per-position digit register file, emits a valid pulse per accepted digit, and emits a frame pulse once every position has been refreshed.

Parameters:
- N_DIG, 4, number of multiplexed display positions (>=1).
- STABLE_CYCLES, 4, consecutive identical samples required before accepting a pattern (>=1).
- CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- segmentos  input  7  segment lines, active low, bit0=a .. bit6=g.
- anodos  input  N_DIG  position selects, active low, one-hot-low when valid.
- digitos  output  4*N_DIG  packed decoded digits; position p at bits [4p+3:4p].
- valido  output  1  one-cycle pulse: a digit was accepted this cycle.
- posicao  output  clog2(N_DIG) (min 1)  position of the accepted digit; valid while valido=1.
- digito  output  4  accepted digit value; valid while valido=1.
- erro  output  1  one-cycle pulse: a stable, non-decodable pattern was seen.
- quadro  output  1  one-cycle pulse: every position accepted at least once since the last quadro.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - digitos = all 4'hF.
  - valido, erro, quadro = 0; posicao = 0; digito = 0.
  - Input registers = all ones; counter = 0; state = IDLE; refresh mask = 0.
- Reset may assert mid-dwell. Any partial count is discarded; no pulse is issued.
- Input stage: segmentos and anodos are registered every clk. All decisions use the registered values.
- Decode table (registered segmentos -> value):
  - 1000000 -> 0, 1111001 -> 1, 0100100 -> 2, 0110000 -> 3, 0011001 -> 4
  - 0010010 -> 5, 0000010 -> 6, 1111000 -> 7, 0000000 -> 8, 0010000 -> 9
  - 1111111 -> 4'hF (blank)
  - Any other pattern -> error.
- Anode validity: exactly one bit of the registered anodos is low. Zero or multiple low bits means invalid.
- State machine:
  - IDLE: anodos invalid. Counter held at 0. Goes to TRACK when anodos becomes valid; counter = 1.
  - TRACK: if the segment or anode sample differs from the previous sample, counter reloads to 1 and the state stays TRACK. If anodos goes invalid, go to IDLE. If the sample is unchanged, counter increments. When the counter reaches STABLE_CYCLES, go to HOLD and issue the acceptance.
  - HOLD: the pattern has been accepted. No further pulses while the sample is unchanged. Any change goes to TRACK (counter = 1), or to IDLE if anodos is invalid.
- Acceptance:
  - Timing: issued on the cycle the state enters HOLD. Latency from the first pin edge carrying the new stable pattern to the valido/erro pulse is STABLE_CYCLES+1 clk edges.
  - Decodable pattern: valido=1 for one cycle, posicao = index of the low anode, digito = decoded value. digitos[posicao] is updated on the same edge, and the mask bit for posicao is set.
  - Non-decodable pattern: erro=1 for one cycle. digitos and mask are unchanged; valido stays 0.
  - valido and erro are never asserted together.
- Frame pulse:
  - When a valido sets the last clear mask bit, quadro=1 in the same cycle as that valido, and the mask clears to 0 on that edge.
  - Repeated acceptance of the same position only re-sets an already-set bit.
- STABLE_CYCLES=1: a pattern is accepted on the first registered sample in which anodos is valid. The state passes through TRACK as a single-cycle transition.
- Arithmetic: the counter saturates at STABLE_CYCLES and never wraps.

Test Plan:
- Reset: after rst_n low then high, with anodos=1111 -> digitos=16'hFFFF; valido, erro, quadro stay 0 for 20 cycles.
- Single digit: anodos=1110, segmentos=0110000 held for 10 cycles (STABLE_CYCLES=4) -> exactly one valido, 5 edges after the pins change, with posicao=0, digito=3; digitos[3:0]=3; no second pulse.
- Glitch rejection: segmentos toggles between 0010010 and 0000010 every 2 cycles on anodos=1101 -> no valido. Then 0000010 held for 6 cycles -> one valido with posicao=1, digito=6.
- Full frame: scan positions 0..3 with patterns for 1, 2, 7, 9, each held 6 cycles -> four valido pulses; quadro coincides with the 4th; digitos=16'h9721; mask cleared afterwards.
- Errors and bad anodes: stable segmentos=0101010 on anodos=1011 -> one erro pulse, digitos unchanged. anodos=1001 with valid 8 held -> no pulse. Blank 1111111 on anodos=0111 -> valido, digito=4'hF.
- Reset mid-dwell: assert rst_n=0 after 2 stable cycles of digit 5 -> no valido; outputs return to reset values immediately, asynchronously, without waiting for clk.
